// File: rtl/l1_ctrl.sv
// l1_ctrl: direct-mapped, write-through, no-write-allocate L1 data cache
// controller. Each line holds one word. Read misses are filled from an L2
// with a fixed response latency; every write is forwarded to the L2.
// Hit and miss statistics are kept in saturating counters.
module l1_ctrl #(
    parameter int WORD_SIZE  = 32,
    parameter int INDEX_SIZE = 3,
    parameter int L2_LATENCY = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_wr_en,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ready,
    output logic                 cpu_resp_valid,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_l1_hit,
    output logic                 cpu_l2_hit,
    output logic                 l2_req,
    output logic                 l2_wr_en,
    output logic [WORD_SIZE-1:0] l2_addr,
    output logic [WORD_SIZE-1:0] l2_wdata,
    input  logic [WORD_SIZE-1:0] l2_rdata,
    input  logic                 l2_hit,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int         LINES     = 1 << INDEX_SIZE;
    localparam int         TAG_W     = WORD_SIZE - INDEX_SIZE - 2;
    // The wait counter runs L2_LATENCY-1 .. 0 so that the L2 response is
    // sampled on the edge closing cycle T+L2_LATENCY (T = l2_req cycle).
    localparam logic [3:0] WAIT_LOAD = 4'(L2_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        L2_REQ  = 3'd2,
        L2_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;

    // Latched CPU request.
    logic [WORD_SIZE-1:0]   req_addr_r;
    logic [WORD_SIZE-1:0]   req_wdata_r;
    logic                   req_wr_r;

    // L1 hit result remembered from LOOKUP for the L2-path response.
    logic                   lookup_hit_r;
    logic [3:0]             wait_cnt_r;

    // Cache storage: {valid, tag, data} per line.
    logic [LINES-1:0]       valid_r;
    logic [TAG_W-1:0]       tag_r  [LINES];
    logic [WORD_SIZE-1:0]   data_r [LINES];

    // Registered outputs.
    logic                   cpu_ready_r;
    logic                   cpu_resp_valid_r;
    logic [WORD_SIZE-1:0]   cpu_rdata_r;
    logic                   cpu_l1_hit_r;
    logic                   cpu_l2_hit_r;
    logic                   l2_req_r;
    logic                   l2_wr_en_r;
    logic [WORD_SIZE-1:0]   l2_addr_r;
    logic [WORD_SIZE-1:0]   l2_wdata_r;
    logic [CNT_WIDTH-1:0]   hit_count_r;
    logic [CNT_WIDTH-1:0]   miss_count_r;

    logic [INDEX_SIZE-1:0]  index_s;
    logic [TAG_W-1:0]       tag_s;
    logic                   hit_s;
    logic                   sample_s;
    logic                   fill_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign index_s  = req_addr_r[INDEX_SIZE+1:2];
    assign tag_s    = req_addr_r[WORD_SIZE-1:INDEX_SIZE+2];
    assign hit_s    = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign sample_s = (state_r == L2_WAIT) && (wait_cnt_r == 4'd0);
    assign fill_s   = sample_s && !req_wr_r && l2_hit;

    // Next-state decode for the request sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    next_state_s = LOOKUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (!req_wr_r && hit_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = L2_REQ;
                end
            end
            L2_REQ: begin
                next_state_s = L2_WAIT;
            end
            L2_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = L2_WAIT;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the CPU request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_r  <= {WORD_SIZE{1'b0}};
            req_wdata_r <= {WORD_SIZE{1'b0}};
            req_wr_r    <= 1'b0;
        end else if (state_r == IDLE && cpu_req) begin
            req_addr_r  <= cpu_addr;
            req_wdata_r <= cpu_wdata;
            req_wr_r    <= cpu_wr_en;
        end
    end

    // Remember the L1 lookup result for the response after the L2 access.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_hit_r <= 1'b0;
        end else if (state_r == LOOKUP) begin
            lookup_hit_r <= hit_s;
        end
    end

    // L2 latency down-counter, loaded while l2_req is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (state_r == L2_REQ) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if (state_r == L2_WAIT && wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // L1 storage: write hits update data in LOOKUP, L2 read hits fill a line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                data_r[i] <= {WORD_SIZE{1'b0}};
            end
        end else if (state_r == LOOKUP && req_wr_r && hit_s) begin
            data_r[index_s] <= req_wdata_r;
        end else if (fill_s) begin
            valid_r[index_s] <= 1'b1;
            tag_r[index_s]   <= tag_s;
            data_r[index_s]  <= l2_rdata;
        end
    end

    // Hit / miss statistics, counted once per request in LOOKUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
        end else if (state_r == LOOKUP) begin
            if (hit_s) begin
                hit_count_r <= sat_inc(hit_count_r);
            end else begin
                miss_count_r <= sat_inc(miss_count_r);
            end
        end
    end

    // Handshake strobes, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ready_r      <= 1'b1;
            cpu_resp_valid_r <= 1'b0;
            l2_req_r         <= 1'b0;
        end else begin
            cpu_ready_r      <= (next_state_s == IDLE);
            cpu_resp_valid_r <= (next_state_s == RESP);
            l2_req_r         <= (next_state_s == L2_REQ);
        end
    end

    // L2 bus: driven from the latched request while the L2 access is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            l2_wr_en_r <= 1'b0;
            l2_addr_r  <= {WORD_SIZE{1'b0}};
            l2_wdata_r <= {WORD_SIZE{1'b0}};
        end else if (next_state_s == L2_REQ || next_state_s == L2_WAIT) begin
            l2_wr_en_r <= req_wr_r;
            l2_addr_r  <= req_addr_r;
            l2_wdata_r <= req_wdata_r;
        end else begin
            l2_wr_en_r <= 1'b0;
            l2_addr_r  <= {WORD_SIZE{1'b0}};
            l2_wdata_r <= {WORD_SIZE{1'b0}};
        end
    end

    // Response payload, updated only on entry to RESP and held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_r  <= {WORD_SIZE{1'b0}};
            cpu_l1_hit_r <= 1'b0;
            cpu_l2_hit_r <= 1'b0;
        end else if (state_r == LOOKUP && next_state_s == RESP) begin
            cpu_rdata_r  <= data_r[index_s];
            cpu_l1_hit_r <= 1'b1;
            cpu_l2_hit_r <= 1'b0;
        end else if (sample_s) begin
            cpu_rdata_r  <= (!req_wr_r && l2_hit) ? l2_rdata : {WORD_SIZE{1'b0}};
            cpu_l1_hit_r <= lookup_hit_r;
            cpu_l2_hit_r <= l2_hit;
        end
    end

    assign cpu_ready      = cpu_ready_r;
    assign cpu_resp_valid = cpu_resp_valid_r;
    assign cpu_rdata      = cpu_rdata_r;
    assign cpu_l1_hit     = cpu_l1_hit_r;
    assign cpu_l2_hit     = cpu_l2_hit_r;
    assign l2_req         = l2_req_r;
    assign l2_wr_en       = l2_wr_en_r;
    assign l2_addr        = l2_addr_r;
    assign l2_wdata       = l2_wdata_r;
    assign hit_count      = hit_count_r;
    assign miss_count     = miss_count_r;

endmodule

// File: tb/tb_l1_ctrl.sv
// tb_l1_ctrl: scoreboard bench for l1_ctrl. A behavioural cache/L2 model
// predicts each response and L2 transaction when a request is issued; monitor
// processes compare whenever the DUT presents a response or an L2 request.
module tb_l1_ctrl;

    localparam int WS   = 32;
    localparam int IS   = 3;
    localparam int LAT  = 2;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          cpu_req    = 1'b0;
    logic          cpu_wr_en  = 1'b0;
    logic [31:0]   cpu_addr   = 32'd0;
    logic [31:0]   cpu_wdata  = 32'd0;
    logic          cpu_ready;
    logic          cpu_resp_valid;
    logic [31:0]   cpu_rdata;
    logic          cpu_l1_hit;
    logic          cpu_l2_hit;
    logic          l2_req;
    logic          l2_wr_en;
    logic [31:0]   l2_addr;
    logic [31:0]   l2_wdata;
    logic [31:0]   l2_rdata   = 32'd0;
    logic          l2_hit     = 1'b0;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    l1_ctrl #(
        .WORD_SIZE (WS),
        .INDEX_SIZE(IS),
        .L2_LATENCY(LAT),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_wr_en     (cpu_wr_en),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ready     (cpu_ready),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata     (cpu_rdata),
        .cpu_l1_hit    (cpu_l1_hit),
        .cpu_l2_hit    (cpu_l2_hit),
        .l2_req        (l2_req),
        .l2_wr_en      (l2_wr_en),
        .l2_addr       (l2_addr),
        .l2_wdata      (l2_wdata),
        .l2_rdata      (l2_rdata),
        .l2_hit        (l2_hit),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        l1_hit;
        logic        l2_hit;
        int          at;
        int          hc;
        int          mc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          at;
        logic        hit;
        logic [31:0] rdata;
    } l2t_t;

    resp_t resp_q[$];
    l2t_t  l2_q[$];

    // Reference model state: L1 lines and an L2 keyed by word address.
    logic        m_valid [8];
    logic [26:0] m_tag   [8];
    logic [31:0] m_data  [8];
    int          m_hits;
    int          m_misses;
    logic [31:0] l2_mem [int];
    int          rst_epoch = 0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Predict the response (and L2 transaction) of a request accepted in cycle c.
    task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int c);
        logic [2:0]  idx;
        logic [26:0] tag;
        int          w;
        logic        hit;
        logic        present;
        resp_t       r;
        l2t_t        t;
        idx = addr[4:2];
        tag = addr[31:5];
        w   = int'(addr[31:2]);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) m_hits++;
        else     m_misses++;
        r.hc = sat(m_hits);
        r.mc = sat(m_misses);
        if (!wr && hit) begin
            r.rdata  = m_data[idx];
            r.l1_hit = 1'b1;
            r.l2_hit = 1'b0;
            r.at     = c + 2;
            resp_q.push_back(r);
        end else begin
            present  = l2_mem.exists(w);
            t.addr   = addr;
            t.wr     = wr;
            t.wdata  = wdata;
            t.at     = c + 2;
            t.hit    = present;
            r.l1_hit = hit;
            r.l2_hit = present;
            r.at     = c + 3 + LAT;
            if (wr) begin
                if (hit) m_data[idx] = wdata;
                l2_mem[w] = wdata;
                t.rdata   = $urandom;
                r.rdata   = 32'd0;
            end else if (present) begin
                t.rdata      = l2_mem[w];
                r.rdata      = l2_mem[w];
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = l2_mem[w];
            end else begin
                t.rdata = $urandom;
                r.rdata = 32'd0;
            end
            l2_q.push_back(t);
            resp_q.push_back(r);
        end
    endtask

    // Wait for cpu_ready (driving ignored junk requests meanwhile), then issue.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) break;
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_wr_en = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            n++;
            if (n > 200) begin
                check("ready_timeout", 32'd0, 32'd1);
                cpu_req = 1'b0;
                return;
            end
        end
        cpu_req   = 1'b1;
        cpu_wr_en = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        predict(wr, addr, wdata, cyc);
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && cpu_resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("resp_cycle", 32'(cyc), 32'(e.at));
                check("resp_rdata", cpu_rdata, e.rdata);
                check("resp_l1_hit", 32'(cpu_l1_hit), 32'(e.l1_hit));
                check("resp_l2_hit", 32'(cpu_l2_hit), 32'(e.l2_hit));
                check("hit_count", 32'(hit_count), 32'(e.hc));
                check("miss_count", 32'(miss_count), 32'(e.mc));
            end
        end
    end

    // L2 bus is quiet whenever the controller is idle; l2_req is a single pulse.
    logic prev_l2_req = 1'b0;
    always @(negedge clk) begin
        if (!rst && cpu_ready === 1'b1)
            check("idle_l2_zero", l2_addr | l2_wdata | {30'd0, l2_req, l2_wr_en}, 32'd0);
        if (!rst && l2_req === 1'b1)
            check("l2_req_pulse", 32'(prev_l2_req), 32'd0);
        prev_l2_req <= l2_req;
    end

    // L2 responder: checks each request and returns data only in cycle T+LAT.
    initial begin
        l2t_t t;
        int   ep;
        forever begin
            @(negedge clk);
            l2_hit   = 1'($urandom_range(0, 1));
            l2_rdata = $urandom;
            if (!rst && l2_req === 1'b1) begin
                if (l2_q.size() == 0) begin
                    check("l2_unexpected_req", 32'd1, 32'd0);
                end else begin
                    t  = l2_q.pop_front();
                    ep = rst_epoch;
                    check("l2_addr", l2_addr, t.addr);
                    check("l2_wr_en", 32'(l2_wr_en), 32'(t.wr));
                    check("l2_wdata", l2_wdata, t.wdata);
                    check("l2_req_cycle", 32'(cyc), 32'(t.at));
                    for (int k = 0; k < LAT; k++) begin
                        @(negedge clk);
                        l2_hit   = 1'($urandom_range(0, 1));
                        l2_rdata = $urandom;
                    end
                    if (ep == rst_epoch) begin
                        check("l2_addr_hold", l2_addr, t.addr);
                        l2_hit   = t.hit;
                        l2_rdata = t.rdata;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // Main stimulus.
    initial begin
        int n;
        logic wr;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) != 0) l2_mem[i] = $urandom;
        end
        l2_mem[5]  = 32'hDEAD_BEEF;
        l2_mem[13] = 32'hCAFE_0034;
        if (l2_mem.exists(16)) l2_mem.delete(16);
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst_outputs", cpu_rdata | {30'd0, cpu_l1_hit, cpu_l2_hit}, 32'd0);
        check("rst_l2_req", 32'(l2_req), 32'd0);
        check("rst_counts", 32'({hit_count, miss_count}), 32'd0);
        rst = 1'b0;

        // Directed: miss/fill, hit, write hit, eviction, L2 miss.
        issue(1'b0, 32'h0000_0014, 32'd0);
        issue(1'b0, 32'h0000_0014, 32'd0);
        issue(1'b1, 32'h0000_0014, 32'h1234_5678);
        issue(1'b0, 32'h0000_0014, 32'd0);
        issue(1'b0, 32'h0000_0034, 32'd0);
        issue(1'b0, 32'h0000_0014, 32'd0);
        issue(1'b0, 32'h0000_0040, 32'd0);
        issue(1'b0, 32'h0000_0040, 32'd0);
        issue(1'b0, 32'h0000_0014, 32'd0);

        // Reset during L2_WAIT.
        issue(1'b0, 32'h0000_0040, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            cpu_req = 1'b0;
            n++;
        end while (l2_req !== 1'b1 && n < 50);
        check("l2_req_seen", 32'(l2_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rst_epoch++;
        resp_q.delete();
        l2_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(cpu_ready), 32'd1);
        check("midrst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("midrst_l2_req", 32'(l2_req), 32'd0);
        check("midrst_counts", 32'({hit_count, miss_count}), 32'd0);
        repeat (8) @(negedge clk);
        issue(1'b0, 32'h0000_0014, 32'd0);

        // Randomized traffic over 4 tags x 8 indices.
        for (int k = 0; k < 300; k++) begin
            wr = ($urandom_range(0, 9) < 3);
            issue(wr, 32'($urandom_range(0, 127)), $urandom);
        end

        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while ((resp_q.size() != 0 || l2_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(resp_q.size() + l2_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
